// File: rtl/uart_rx_frame.sv
// 16x-oversampled UART receiver with a valid/ready holding register and
// error pulses. Define UART_RX_PARITY_EN to expect an even-parity bit.
module uart_rx_frame #(
  parameter int SYS_CLK_FREQ = 200_000_000,
  parameter int BAUD_RATE    = 19200,
  parameter int FRAME_WIDTH  = 8,
  parameter int OVERSAMPLE   = 16
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [0:FRAME_WIDTH-1] dout,
  output logic                   so,
  input  logic                   ro,
  output logic                   frame_err,
  output logic                   parity_err,
  output logic                   overrun
);

  localparam int DIV = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(FRAME_WIDTH + 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(DIV - 1);
  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(FRAME_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_START     = 3'd1,
    S_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY    = 3'd3,
`endif
    S_STOP      = 3'd4,
    S_WAIT_IDLE = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   rx_m_q, rx_s_q;
  logic                   arm_q;
  logic [DW-1:0]          div_q, div_d;
  logic [TW-1:0]          tcnt_q, tcnt_d;
  logic [BW-1:0]          bcnt_q, bcnt_d;
  logic [FRAME_WIDTH-1:0] sh_q, sh_d;
  logic [0:FRAME_WIDTH-1] dout_q, dout_d;
  logic                   so_q, so_d;
  logic                   ferr_q, ferr_d;
  logic                   ovr_q, ovr_d;
  logic                   tick;
  logic                   good;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad_q, par_bad_d;
  logic                   perr_q, perr_d;
`endif

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = tick ? '0 : div_q + 1'b1;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    sh_d    = sh_q;
    dout_d  = dout_q;
    so_d    = so_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    good    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d = par_bad_q;
    perr_d    = 1'b0;
`endif
    if (so_q && ro) so_d = 1'b0;

    case (state_q)
      // arm_q blocks a start edge until the line has been seen idle after reset
      S_IDLE: begin
        if (arm_q && !rx_s_q) begin
          state_d = S_START;
          div_d   = '0;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (tick) begin
          if (tcnt_q == HALF_LAST) begin
            tcnt_d = '0;
            bcnt_d = '0;
            state_d = rx_s_q ? S_IDLE : S_DATA;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d = '0;
            sh_d   = {rx_s_q, sh_q[FRAME_WIDTH-1:1]};
            if (bcnt_q == BITS_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d    = '0;
            par_bad_d = (^sh_q) ^ rx_s_q;
            state_d   = S_STOP;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (tcnt_q == FULL_LAST) begin
            tcnt_d = '0;
`ifdef UART_RX_PARITY_EN
            perr_d = par_bad_q;
`endif
            if (rx_s_q) begin
`ifdef UART_RX_PARITY_EN
              good = !par_bad_q;
`else
              good = 1'b1;
`endif
              state_d = S_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = S_WAIT_IDLE;
            end
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A consume in the same cycle frees the register for the new word
    if (good) begin
      if (!so_q || ro) begin
        dout_d = sh_q;
        so_d   = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      rx_m_q  <= 1'b1;
      rx_s_q  <= 1'b1;
      arm_q   <= 1'b0;
      state_q <= S_IDLE;
      div_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      sh_q    <= '0;
      dout_q  <= '0;
      so_q    <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_m_q  <= rx;
      rx_s_q  <= rx_m_q;
      if (rx_s_q) arm_q <= 1'b1;
      state_q <= state_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      dout_q  <= dout_d;
      so_q    <= so_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= par_bad_d;
      perr_q    <= perr_d;
`endif
    end
  end

  assign dout      = dout_q;
  assign so        = so_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame, scaled to 3 sys clocks per sample tick
// (48 clocks per bit) so every frame stays short.
module tb_uart_rx_frame;

  localparam int CLK_HZ  = 3_000_000;
  localparam int BAUD    = 62_500;
  localparam int FW      = 8;
  localparam int OS      = 16;
  localparam int BIT_CYC = 48;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          rx;
  logic          ro;
  logic [0:FW-1] dout;
  logic          so;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  int n_vec = 0;
  int n_err = 0;
  int got_cnt = 0, ferr_cnt = 0, perr_cnt = 0, ovr_cnt = 0;
  int exp_got = 0, exp_ferr = 0, exp_perr = 0, exp_ovr = 0;
  logic [7:0] last_word = 8'h00;

  uart_rx_frame #(
    .SYS_CLK_FREQ(CLK_HZ),
    .BAUD_RATE   (BAUD),
    .FRAME_WIDTH (FW),
    .OVERSAMPLE  (OS)
  ) dut (
    .sys_clk   (clk),
    .reset     (reset),
    .rx        (rx),
    .dout      (dout),
    .so        (so),
    .ro        (ro),
    .frame_err (frame_err),
    .parity_err(parity_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after posedge; outputs are observed at negedge.
  always @(negedge clk) begin
    if (!reset) begin
      if (so && ro) begin
        got_cnt   <= got_cnt + 1;
        last_word <= dout;
      end
      if (frame_err)  ferr_cnt <= ferr_cnt + 1;
      if (parity_err) perr_cnt <= perr_cnt + 1;
      if (overrun)    ovr_cnt  <= ovr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves rx at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic stp);
    logic [10:0] f;
    f = {stp, p, d, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (PAR_EN || i != 9) begin
        rx = f[i];
        cyc(BIT_CYC);
      end
    end
  endtask

  task automatic chk_flags(input string tag);
    chk({tag, "_ferr"}, ferr_cnt, exp_ferr);
    chk({tag, "_perr"}, perr_cnt, exp_perr);
    chk({tag, "_ovr"},  ovr_cnt,  exp_ovr);
  endtask

  task automatic rx_good(input string tag, input logic [7:0] d);
    send_frame(d, ^d, 1'b1);
    cyc(2);
    exp_got++;
    chk({tag, "_cnt"},  got_cnt, exp_got);
    chk({tag, "_word"}, last_word, d);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] tbl [4];
    tbl[0] = 8'h00; tbl[1] = 8'hFF; tbl[2] = 8'h80; tbl[3] = 8'h01;
    reset = 1'b1;
    rx    = 1'b1;
    ro    = 1'b1;
    cyc(3);
    chk("rst_so",   so, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ovr",  overrun, 0);
    reset = 1'b0;
    cyc(BIT_CYC);

    rx_good("a5", 8'hA5);
    cyc(2 * BIT_CYC);
    chk("a5_so_low", so, 0);
    chk_flags("a5");

    rx = 1'b0;
    cyc(8);
    rx = 1'b1;
    cyc(2 * BIT_CYC);
    chk("glitch_cnt", got_cnt, exp_got);
    chk_flags("glitch");
    rx_good("5a", 8'h5A);

    send_frame(8'h3C, ^8'h3C, 1'b0);
    cyc(100);
    chk("brk_cnt", got_cnt, exp_got);
    rx = 1'b1;
    cyc(2 * BIT_CYC);
    exp_ferr++;
    chk_flags("brk");
    rx_good("3c", 8'h3C);

    ro = 1'b0;
    send_frame(8'h11, ^8'h11, 1'b1);
    send_frame(8'h22, ^8'h22, 1'b1);
    cyc(BIT_CYC);
    exp_ovr++;
    chk("ovr_so",   so, 1);
    chk("ovr_dout", dout, 8'h11);
    chk("ovr_cnt",  got_cnt, exp_got);
    chk_flags("ovr");
    ro = 1'b1;
    cyc(3);
    exp_got++;
    chk("ovr_drain_cnt",  got_cnt, exp_got);
    chk("ovr_drain_word", last_word, 8'h11);
    chk("ovr_drain_so",   so, 0);

    rx = 1'b0;
    cyc(BIT_CYC);
    rx = 1'b1;
    cyc(4 * BIT_CYC + BIT_CYC / 2);
    reset = 1'b1;
    cyc(2);
    chk("midrst_so", so, 0);
    reset = 1'b0;
    cyc(6 * BIT_CYC);
    chk("midrst_cnt", got_cnt, exp_got);
    rx_good("81", 8'h81);
    chk_flags("81");

    for (int i = 0; i < 4; i++) rx_good("b2b", tbl[i]);
    chk_flags("b2b");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 1'b1);
    cyc(2 * BIT_CYC);
    exp_perr++;
    chk("par_bad_cnt", got_cnt, exp_got);
    chk_flags("par_bad");
    rx_good("par_ok", 8'h07);
    chk_flags("par_ok");
`endif

    cyc(BIT_CYC);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
